bit_serial_mac_seq: RTL
=======================

# bit_serial_mac_seq

Parametrised bit-serial (Stripes-style) dot-product engine. Each beat presents one weight bit-column across `VEC_LENGTH` lanes. The block masks activations by weight bit, reduces them in an adder tree, shifts by an internally tracked column index, applies two's-complement negation on the signed MSB column, and accumulates internally over a runtime-selectable weight precision. A finished dot product leaves through a valid/ready output port. The block sits between the activation/weight-bit buffers and the output-accumulation / requantisation stage of a PE column.

## Interface
- `DATA_WIDTH`, 8: signed activation width.
- `VEC_LENGTH`, 16: lanes per beat; power of two, ≥2.
- `W_PREC_MAX`, 8: maximum weight precision (bit columns per job), ≥1.
- `SUM_WIDTH`, DATA_WIDTH+$clog2(VEC_LENGTH): column-sum width (derived).
- `ACC_WIDTH`, SUM_WIDTH+W_PREC_MAX+2: accumulator/result width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous abort; discards the job in progress.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid & in_ready` at a rising edge.
- `act` in DATA_WIDTH×VEC_LENGTH: signed activations, unpacked array.
- `w_bit` in 1×VEC_LENGTH: weight bits of the current column, unpacked array.
- `w_prec` in $clog2(W_PREC_MAX+1): columns in the job; sampled on the first beat only.
- `signed_mode` in 1: 1 = weights are two's complement (MSB column negative); sampled on the first beat.
- `load_accum` in 1: 1 = seed the accumulator with `accum_prev`, 0 = seed with 0; sampled on the first beat.
- `accum_prev` in ACC_WIDTH: signed seed value.
- `out_valid` out 1: `result` holds a finished dot product.
- `out_ready` in 1: downstream accepts `result`.
- `result` out ACC_WIDTH: signed accumulated dot product.
- `busy` out 1: high while a job is in progress (state ACCUM).

## Operation
- States:
  - IDLE: no job in progress.
  - ACCUM: beats of a job are being accepted.
  - DONE: result held until accepted.
- Outputs:
  - `in_ready` = (state != DONE).
  - `out_valid` = (state == DONE).
  - `busy` = (state == ACCUM).
- Column sum: `csum` = Σ over j of (`w_bit[j]` ? `act[j]` : 0), signed, SUM_WIDTH bits, exact (cannot overflow).
- Column index `col`: counts 0..P-1, LSB column first, where P = `w_prec` latched on the first beat.
  - `w_prec` = 0 is treated as P = 1.
  - `w_prec` > W_PREC_MAX is treated as P = W_PREC_MAX.
- Term: `term` = sign-extend(`csum`) <<< `col`, computed at ACC_WIDTH.
  - Negated (two's complement) when `col` == P-1 and the latched `signed_mode` = 1.
- First beat, accepted in IDLE:
  - `acc` = (`load_accum` ? `accum_prev` : 0) + `term`.
  - Latch `w_prec` (as P) and `signed_mode`.
  - `col` = 1.
  - If P = 1, go to DONE; else go to ACCUM.
- Subsequent beats, accepted in ACCUM:
  - `acc` += `term`; `col` += 1.
  - On the beat where `col` == P-1, go to DONE and reset `col` to 0.
- Arithmetic wraps modulo 2^ACC_WIDTH; no saturation.
- In DONE: `result` = `acc`, stable. The `out_valid & out_ready` handshake moves the block to IDLE.
- `clear`:
  - Forces IDLE, `col` = 0, `acc` = 0 on the next edge.
  - Has priority over a simultaneous beat or output handshake; both are discarded.
  - A result pending in DONE is dropped.
- `reset` (asynchronous): state IDLE, `col` 0, `acc` 0, latched P and mode cleared. Applies immediately, including mid-job.

## Timing
- Reset values: `out_valid` 0, `result` 0, `busy` 0, `in_ready` 1.
- Throughput: one column per clock while `in_ready` is high.
- Latency: `out_valid` rises on the edge that accepts the last beat, so `result` is valid in the following cycle.
- A P-column job therefore occupies P cycles plus at least one cycle in DONE.
- `in_ready` is low throughout DONE. No bypass: a new job's first beat is accepted at the earliest one cycle after the output handshake.
- Input `act`, `w_bit` and control signals may change freely between accepted beats.
- `in_valid` low in ACCUM inserts bubbles. `acc` and `col` hold; there is no timeout.
- `result`, `out_valid` and `busy` come from registers. `in_ready` is decoded from state only and has no combinational path from any input.

## Test plan
1. Signed, P=4, all `act`=1, all `w_bit`=1 for 4 beats (weight −1), `load_accum`=0.
   - Required: one cycle after beat 4, `out_valid`=1 and `result`=16·(1+2+4)−16·8 = −16.
2. Unsigned, P=8, all `act`=−128, all `w_bit`=1, `load_accum`=1, `accum_prev`=1000.
   - Required: `result`=1000 + (−2048·255) = −521240.
3. Back-pressure:
   - Hold `out_ready`=0 for 5 cycles after a job finishes. Required: `result` stable, `in_ready`=0, offered beats not accepted.
   - Raise `out_ready`. Required: IDLE; the next beat is accepted one cycle later.
4. Bubbles and precision edge cases:
   - Signed P=3 with `in_valid` low for 2 cycles between beats, `w_bit` lane0 only, `act[0]`=5, columns 1,0,1. Required: `result`=5−20=−15.
   - `w_prec`=0. Required: single-beat job, `result` = −`csum` (signed) or `csum` (unsigned).
5. `clear` on beat 2 of a P=4 job, with `in_valid`=1 simultaneously. Required: next cycle IDLE, `busy`=0; a following fresh job gives a result unaffected by the aborted beats.
6. Assert `reset` asynchronously mid-job, away from a clock edge. Required: `busy`, `out_valid` and `result` go to 0 immediately; a job after deassertion computes correctly.

Source files
------------

// File: rtl/bit_serial_mac_seq.sv
// Bit-serial (Stripes-style) dot-product engine: one weight bit-column per beat,
// masked adder-tree reduction, shift by column index, signed-MSB negation, internal accumulation.
module bit_serial_mac_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int W_PREC_MAX = 8,
  parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(VEC_LENGTH),
  parameter int ACC_WIDTH  = SUM_WIDTH + W_PREC_MAX + 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             act [VEC_LENGTH],
  input  logic                              w_bit [VEC_LENGTH],
  input  logic [$clog2(W_PREC_MAX+1)-1:0]   w_prec,
  input  logic                              signed_mode,
  input  logic                              load_accum,
  input  logic [ACC_WIDTH-1:0]              accum_prev,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_WIDTH-1:0]              result,
  output logic                              busy,
  output logic [1:0]                        dbg_state
);

  localparam int PW = $clog2(W_PREC_MAX + 1);

  // Handshakes: a beat transfers when in_valid & in_ready at a rising edge; a result
  // transfers when out_valid & out_ready at a rising edge. Neither ready depends on its valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         col_q, col_d;
  logic [PW-1:0]         p_q, p_d;
  logic                  mode_q, mode_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;

  logic signed [SUM_WIDTH-1:0] csum;
  logic [ACC_WIDTH-1:0]        term;
  logic [ACC_WIDTH-1:0]        base;
  logic [PW-1:0]               p_in;
  logic [PW-1:0]               p_cur;
  logic                        mode_cur;
  logic                        first;
  logic                        last;
  logic                        accept;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM);
  assign result    = acc_q;
  assign dbg_state = state_q;

  always_comb begin
    csum = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      if (w_bit[j]) begin
        csum = csum + $signed({{(SUM_WIDTH-DATA_WIDTH){act[j][DATA_WIDTH-1]}}, act[j]});
      end
    end
  end

  always_comb begin
    // Zero precision behaves as a single column; oversize precision clamps to the maximum.
    p_in = w_prec;
    if (w_prec == '0) begin
      p_in = PW'(1);
    end else if (w_prec > PW'(W_PREC_MAX)) begin
      p_in = PW'(W_PREC_MAX);
    end
  end

  always_comb begin
    first    = (state_q == IDLE);
    p_cur    = first ? p_in : p_q;
    mode_cur = first ? signed_mode : mode_q;
    last     = (col_q == (p_cur - PW'(1)));
    accept   = in_valid & in_ready;
    base     = first ? (load_accum ? accum_prev : '0) : acc_q;
    term     = {{(ACC_WIDTH-SUM_WIDTH){csum[SUM_WIDTH-1]}}, csum} << col_q;
    if (last && mode_cur) begin
      term = -term;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    p_d     = p_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    if (clear) begin
      state_d = IDLE;
      col_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d  = base + term;
            p_d    = p_in;
            mode_d = signed_mode;
            if (last) begin
              state_d = DONE;
              col_d   = '0;
            end else begin
              state_d = ACCUM;
              col_d   = PW'(1);
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = base + term;
            if (last) begin
              state_d = DONE;
              col_d   = '0;
            end else begin
              col_d = col_q + PW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          col_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      p_q     <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
    end
  end

endmodule
